// File: rtl/sram_port_arbiter.sv
// Arbitrates the CPU fetch and load/store ports onto one single-port synchronous SRAM.
// One access is in flight at a time; reads wait RD_LAT cycles, writes finish in the issue cycle.
module sram_port_arbiter #(
  parameter int unsigned RD_LAT    = 1,
  parameter bit          DATA_PRIO = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst_rdata,
  output logic        inst_stall,
  input  logic        data_req,
  input  logic [3:0]  data_wen,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_stall,
  output logic        mem_en,
  output logic [3:0]  mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned CNT_W = $clog2(RD_LAT + 1);

  typedef enum logic {IDLE, WAIT} state_e;
  typedef enum logic {GNT_INST = 1'b0, GNT_DATA = 1'b1} gnt_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  gnt_e             gnt_q, gnt_d;
  gnt_e             last_gnt_q, last_gnt_d;
  logic [31:0]      inst_hold_q, inst_hold_d;
  logic [31:0]      data_hold_q, data_hold_d;

  gnt_e winner;
  logic inst_done;
  logic data_done;

  // Round-robin hands a simultaneous request to the side opposite the last grant.
  always_comb begin
    if (data_req && inst_req) begin
      winner = (DATA_PRIO || last_gnt_q == GNT_INST) ? GNT_DATA : GNT_INST;
    end else if (data_req) begin
      winner = GNT_DATA;
    end else begin
      winner = GNT_INST;
    end
  end

  always_comb begin
    // NOTE: every output and next-state value gets a default first so no path leaves one unassigned (no latches).
    state_d     = state_q;
    cnt_d       = cnt_q;
    gnt_d       = gnt_q;
    last_gnt_d  = last_gnt_q;
    inst_hold_d = inst_hold_q;
    data_hold_d = data_hold_q;
    mem_en      = 1'b0;
    mem_wen     = 4'b0000;
    mem_addr    = 32'h0;
    mem_wdata   = 32'h0;
    inst_rdata  = inst_hold_q;
    data_rdata  = data_hold_q;
    inst_done   = 1'b0;
    data_done   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (inst_req || data_req) begin
          mem_en     = 1'b1;
          last_gnt_d = winner;
          if (winner == GNT_DATA) begin
            mem_addr  = data_addr;
            mem_wen   = data_wen;
            mem_wdata = data_wdata;
          end else begin
            mem_addr  = inst_addr;
          end
          if (winner == GNT_DATA && data_wen != 4'b0000) begin
            data_done = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_W'(1);
            gnt_d   = winner;
          end
        end
      end
      WAIT: begin
        if (cnt_q == CNT_W'(RD_LAT)) begin
          state_d = IDLE;
          if (gnt_q == GNT_DATA) begin
            data_rdata  = mem_rdata;
            data_hold_d = mem_rdata;
            data_done   = 1'b1;
          end else begin
            inst_rdata  = mem_rdata;
            inst_hold_d = mem_rdata;
            inst_done   = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    inst_stall = inst_req & ~inst_done;
    data_stall = data_req & ~data_done;

    // Reset silences the memory and both requesters; an in-flight read never reports done.
    if (rst) begin
      mem_en     = 1'b0;
      mem_wen    = 4'b0000;
      mem_addr   = 32'h0;
      mem_wdata  = 32'h0;
      inst_rdata = 32'h0;
      data_rdata = 32'h0;
      inst_stall = 1'b0;
      data_stall = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= CNT_W'(1);
      gnt_q       <= GNT_INST;
      last_gnt_q  <= GNT_INST;
      inst_hold_q <= 32'h0;
      data_hold_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      gnt_q       <= gnt_d;
      last_gnt_q  <= last_gnt_d;
      inst_hold_q <= inst_hold_d;
      data_hold_q <= data_hold_d;
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Scoreboard bench: three arbiter instances (lat1/prio, lat1/round-robin, lat3/prio) driven by directed vectors.
module tb_sram_port_arbiter;

  localparam int N = 3;

  typedef struct {
    int          cyc;
    logic [31:0] a;
    logic [3:0]  w;
    logic [31:0] d;
    logic        chk;
  } ev_t;

  typedef struct {
    int          cyc;
    logic        men;
    logic        ist;
    logic        dst;
    logic        chk_rd;
    logic [31:0] ird;
    logic [31:0] drd;
    logic        chk_addr;
    logic [31:0] addr;
  } pr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req   [N];
  logic [31:0] inst_addr  [N];
  logic        data_req   [N];
  logic [3:0]  data_wen   [N];
  logic [31:0] data_addr  [N];
  logic [31:0] data_wdata [N];
  logic [31:0] mem_rdata  [N];

  int cyc   = 0;
  int total = 0;
  int bad   = 0;

  ev_t iss_q  [N][$];
  ev_t inst_q [N][$];
  ev_t data_q [N][$];
  pr_t pr_q   [N][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int g, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d cyc=%0d: got %h want %h", name, g, cyc, act, exp);
    end
  endtask

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int unsigned LAT  = (g == 2) ? 3 : 1;
    localparam bit          PRIO = (g == 1) ? 1'b0 : 1'b1;

    logic [31:0] inst_rdata, data_rdata, mem_addr, mem_wdata;
    logic        inst_stall, data_stall, mem_en;
    logic [3:0]  mem_wen;

    sram_port_arbiter #(.RD_LAT(LAT), .DATA_PRIO(PRIO)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .inst_req   (inst_req[g]),
      .inst_addr  (inst_addr[g]),
      .inst_rdata (inst_rdata),
      .inst_stall (inst_stall),
      .data_req   (data_req[g]),
      .data_wen   (data_wen[g]),
      .data_addr  (data_addr[g]),
      .data_wdata (data_wdata[g]),
      .data_rdata (data_rdata),
      .data_stall (data_stall),
      .mem_en     (mem_en),
      .mem_wen    (mem_wen),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata[g])
    );

    // Monitor: sample away from the rising edge and retire scoreboard entries.
    always @(negedge clk) begin
      ev_t e;
      pr_t p;
      if (!rst) begin
        if (mem_en) begin
          if (iss_q[g].size() == 0) begin
            check("unexpected_issue", g, 32'(mem_addr), 32'hFFFF_FFFF);
          end else begin
            e = iss_q[g].pop_front();
            check("issue_cyc", g, 32'(cyc), 32'(e.cyc));
            check("issue_addr", g, mem_addr, e.a);
            check("issue_wen", g, 32'(mem_wen), 32'(e.w));
            check("issue_wdata", g, mem_wdata, e.d);
          end
        end
        if (inst_req[g] && !inst_stall) begin
          if (inst_q[g].size() == 0) begin
            check("unexpected_inst_done", g, 32'(cyc), 32'hFFFF_FFFF);
          end else begin
            e = inst_q[g].pop_front();
            check("inst_done_cyc", g, 32'(cyc), 32'(e.cyc));
            if (e.chk) check("inst_rdata", g, inst_rdata, e.d);
          end
        end
        if (data_req[g] && !data_stall) begin
          if (data_q[g].size() == 0) begin
            check("unexpected_data_done", g, 32'(cyc), 32'hFFFF_FFFF);
          end else begin
            e = data_q[g].pop_front();
            check("data_done_cyc", g, 32'(cyc), 32'(e.cyc));
            if (e.chk) check("data_rdata", g, data_rdata, e.d);
          end
        end
      end
      while (pr_q[g].size() != 0 && pr_q[g][0].cyc == cyc) begin
        p = pr_q[g].pop_front();
        check("probe_mem_en", g, 32'(mem_en), 32'(p.men));
        check("probe_inst_stall", g, 32'(inst_stall), 32'(p.ist));
        check("probe_data_stall", g, 32'(data_stall), 32'(p.dst));
        if (p.chk_rd) begin
          check("probe_inst_rdata", g, inst_rdata, p.ird);
          check("probe_data_rdata", g, data_rdata, p.drd);
        end
        if (p.chk_addr) check("probe_mem_addr", g, mem_addr, p.addr);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    for (int i = 0; i < N; i++) begin
      inst_req[i]   = 1'b0;
      inst_addr[i]  = 32'h0;
      data_req[i]   = 1'b0;
      data_wen[i]   = 4'b0;
      data_addr[i]  = 32'h0;
      data_wdata[i] = 32'h0;
      mem_rdata[i]  = 32'h0;
    end
  endtask

  function automatic void exp_iss(int g, int c, logic [31:0] a, logic [3:0] w, logic [31:0] d);
    ev_t e;
    e.cyc = c; e.a = a; e.w = w; e.d = d; e.chk = 1'b1;
    iss_q[g].push_back(e);
  endfunction

  function automatic void exp_inst(int g, int c, logic [31:0] d);
    ev_t e;
    e.cyc = c; e.a = 32'h0; e.w = 4'h0; e.d = d; e.chk = 1'b1;
    inst_q[g].push_back(e);
  endfunction

  function automatic void exp_data(int g, int c, logic [31:0] d, logic chk);
    ev_t e;
    e.cyc = c; e.a = 32'h0; e.w = 4'h0; e.d = d; e.chk = chk;
    data_q[g].push_back(e);
  endfunction

  function automatic void exp_pr(int g, int c, logic men, logic ist, logic dst, logic chk_rd,
                                 logic [31:0] ird, logic [31:0] drd, logic chk_addr, logic [31:0] addr);
    pr_t p;
    p.cyc = c; p.men = men; p.ist = ist; p.dst = dst; p.chk_rd = chk_rd;
    p.ird = ird; p.drd = drd; p.chk_addr = chk_addr; p.addr = addr;
    pr_q[g].push_back(p);
  endfunction

  initial begin
    int t;
    rst = 1'b1;
    idle_all();
    step(); step();

    // Reset holds everything quiet even with a fetch pending.
    t = cyc;
    inst_req[0] = 1'b1; inst_addr[0] = 32'hBFC0_0000;
    exp_pr(0, t, 0, 0, 0, 1, 32'h0, 32'h0, 1, 32'h0);

    // RD_LAT=1 fetch: pending request re-arbitrated on the first cycle after reset.
    step(); t = cyc; rst = 1'b0;
    exp_iss(0, t, 32'hBFC0_0000, 4'h0, 32'h0);
    exp_pr(0, t, 1, 1, 0, 1, 32'h0, 32'h0, 1, 32'hBFC0_0000);
    step(); mem_rdata[0] = 32'h2401_0001;
    exp_inst(0, t + 1, 32'h2401_0001);
    exp_pr(0, t + 1, 0, 0, 0, 1, 32'h2401_0001, 32'h0, 0, 32'h0);
    step(); inst_req[0] = 1'b0; mem_rdata[0] = 32'hDEAD_BEEF;
    exp_pr(0, t + 2, 0, 0, 0, 1, 32'h2401_0001, 32'h0, 1, 32'h0);
    step();
    exp_pr(0, t + 3, 0, 0, 0, 1, 32'h2401_0001, 32'h0, 0, 32'h0);

    // Data priority: simultaneous read requests.
    step(); t = cyc; mem_rdata[0] = 32'h0;
    data_req[0] = 1'b1; data_addr[0] = 32'h8000_0010;
    inst_req[0] = 1'b1; inst_addr[0] = 32'hBFC0_0004;
    exp_iss(0, t, 32'h8000_0010, 4'h0, 32'h0);
    exp_pr(0, t, 1, 1, 1, 1, 32'h2401_0001, 32'h0, 0, 32'h0);
    step(); mem_rdata[0] = 32'h1111_2222;
    exp_data(0, t + 1, 32'h1111_2222, 1'b1);
    exp_pr(0, t + 1, 0, 1, 0, 1, 32'h2401_0001, 32'h1111_2222, 0, 32'h0);
    step(); data_req[0] = 1'b0; mem_rdata[0] = 32'h0;
    exp_iss(0, t + 2, 32'hBFC0_0004, 4'h0, 32'h0);
    exp_pr(0, t + 2, 1, 1, 0, 1, 32'h2401_0001, 32'h1111_2222, 0, 32'h0);
    step(); mem_rdata[0] = 32'h3333_4444;
    exp_inst(0, t + 3, 32'h3333_4444);
    exp_pr(0, t + 3, 0, 0, 0, 1, 32'h3333_4444, 32'h1111_2222, 0, 32'h0);
    step(); inst_req[0] = 1'b0; mem_rdata[0] = 32'h0;

    // Write completes in its issue cycle; stale data_wen ignored on the following fetch.
    step(); t = cyc;
    data_req[0] = 1'b1; data_wen[0] = 4'b0011; data_addr[0] = 32'h10; data_wdata[0] = 32'h1234;
    inst_req[0] = 1'b1; inst_addr[0] = 32'hBFC0_0008;
    exp_iss(0, t, 32'h10, 4'b0011, 32'h1234);
    exp_data(0, t, 32'h0, 1'b0);
    exp_pr(0, t, 1, 1, 0, 0, 32'h0, 32'h0, 0, 32'h0);
    step(); data_req[0] = 1'b0;
    exp_iss(0, t + 1, 32'hBFC0_0008, 4'h0, 32'h0);
    step(); mem_rdata[0] = 32'h5555_6666;
    exp_inst(0, t + 2, 32'h5555_6666);
    step(); inst_req[0] = 1'b0; data_wen[0] = 4'b0; mem_rdata[0] = 32'h0;

    // Round-robin with both sides continuously requesting reads.
    step(); t = cyc;
    data_req[1] = 1'b1; data_addr[1] = 32'hA000_0000;
    inst_req[1] = 1'b1; inst_addr[1] = 32'hB000_0000;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) step();
      mem_rdata[1] = 32'hC0DE_0000 + 32'(k);
      case (k % 4)
        0: exp_iss(1, t + k, 32'hA000_0000, 4'h0, 32'h0);
        1: exp_data(1, t + k, 32'hC0DE_0000 + 32'(k), 1'b1);
        2: exp_iss(1, t + k, 32'hB000_0000, 4'h0, 32'h0);
        default: exp_inst(1, t + k, 32'hC0DE_0000 + 32'(k));
      endcase
      exp_pr(1, t + k, (k % 2) == 0, (k % 4) != 3, (k % 4) != 1, 0, 32'h0, 32'h0, 0, 32'h0);
    end
    step(); data_req[1] = 1'b0; inst_req[1] = 1'b0; mem_rdata[1] = 32'h0;

    // RD_LAT=3 data read; intermediate memory values must not leak.
    step(); t = cyc;
    data_req[2] = 1'b1; data_addr[2] = 32'h8000_0020;
    exp_iss(2, t, 32'h8000_0020, 4'h0, 32'h0);
    exp_pr(2, t, 1, 0, 1, 1, 32'h0, 32'h0, 0, 32'h0);
    step(); mem_rdata[2] = 32'h1111_AAAA;
    exp_pr(2, t + 1, 0, 0, 1, 1, 32'h0, 32'h0, 0, 32'h0);
    step(); mem_rdata[2] = 32'h2222_BBBB;
    exp_pr(2, t + 2, 0, 0, 1, 1, 32'h0, 32'h0, 0, 32'h0);
    step(); mem_rdata[2] = 32'hCAFE_F00D;
    exp_data(2, t + 3, 32'hCAFE_F00D, 1'b1);
    exp_pr(2, t + 3, 0, 0, 0, 1, 32'h0, 32'hCAFE_F00D, 0, 32'h0);
    step(); data_req[2] = 1'b0; mem_rdata[2] = 32'h0;
    exp_pr(2, t + 4, 0, 0, 0, 1, 32'h0, 32'hCAFE_F00D, 1, 32'h0);

    // RD_LAT=3 read with request dropped mid-WAIT; new fetch waits for IDLE.
    step(); t = cyc;
    data_req[2] = 1'b1; data_addr[2] = 32'h8000_0030;
    exp_iss(2, t, 32'h8000_0030, 4'h0, 32'h0);
    step(); data_req[2] = 1'b0;
    exp_pr(2, t + 1, 0, 0, 0, 1, 32'h0, 32'hCAFE_F00D, 0, 32'h0);
    step(); inst_req[2] = 1'b1; inst_addr[2] = 32'hBFC0_0020;
    exp_pr(2, t + 2, 0, 1, 0, 1, 32'h0, 32'hCAFE_F00D, 0, 32'h0);
    step(); mem_rdata[2] = 32'h0BAD_F00D;
    exp_pr(2, t + 3, 0, 1, 0, 1, 32'h0, 32'h0BAD_F00D, 0, 32'h0);
    step(); mem_rdata[2] = 32'h0;
    exp_iss(2, t + 4, 32'hBFC0_0020, 4'h0, 32'h0);
    exp_pr(2, t + 4, 1, 1, 0, 1, 32'h0, 32'h0BAD_F00D, 0, 32'h0);
    step(); step();
    step(); mem_rdata[2] = 32'h1234_5678;
    exp_inst(2, t + 7, 32'h1234_5678);
    step(); inst_req[2] = 1'b0; mem_rdata[2] = 32'h0;

    // Reset during an RD_LAT=1 fetch WAIT discards the read and clears the holds.
    step(); t = cyc;
    inst_req[0] = 1'b1; inst_addr[0] = 32'hBFC0_0010;
    exp_iss(0, t, 32'hBFC0_0010, 4'h0, 32'h0);
    step(); rst = 1'b1; mem_rdata[0] = 32'h7777_7777;
    exp_pr(0, t + 1, 0, 0, 0, 1, 32'h0, 32'h0, 1, 32'h0);
    step(); rst = 1'b0; mem_rdata[0] = 32'h0;
    exp_iss(0, t + 2, 32'hBFC0_0010, 4'h0, 32'h0);
    exp_pr(0, t + 2, 1, 1, 0, 1, 32'h0, 32'h0, 1, 32'hBFC0_0010);
    step(); mem_rdata[0] = 32'h8888_8888;
    exp_inst(0, t + 3, 32'h8888_8888);
    step(); inst_req[0] = 1'b0; mem_rdata[0] = 32'h0;
    exp_pr(0, t + 4, 0, 0, 0, 1, 32'h8888_8888, 32'h0, 0, 32'h0);
    step(); step();

    for (int g = 0; g < N; g++) begin
      check("issues_left", g, 32'(iss_q[g].size()), 32'h0);
      check("inst_done_left", g, 32'(inst_q[g].size()), 32'h0);
      check("data_done_left", g, 32'(data_q[g].size()), 32'h0);
      check("probes_left", g, 32'(pr_q[g].size()), 32'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
